// File: rtl/seconds_pkg.sv
// rtl/seconds_pkg.sv - shared count limits and state type for the seconds counter
package seconds_pkg;

  localparam int MAX_COUNT = 59;
  localparam int COUNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // True when a count value lies inside the legal 0..MAX_COUNT window.
  function automatic logic count_in_range(input logic [COUNT_W-1:0] value);
    return value <= COUNT_W'(MAX_COUNT);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-DIV prescaler producing the count step strobe
module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int           W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // The step fires in the same cycle the counter rolls over, so the parent can
  // register count/tick/wrap on that very edge; a clear suppresses the step.
  assign tick = en && !clr && (cnt == LAST);

  // Count 0..DIV-1 while enabled, hold while disabled, clear has priority.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/seconds_counter.sv
// rtl/seconds_counter.sv - run/pause/clear seconds counter 0..59; SECONDS_COUNTDOWN_EN selects counting down
module seconds_counter
  import seconds_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [1:0]         KEY,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               tick,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] TOP = COUNT_W'(MAX_COUNT);

`ifdef SECONDS_COUNTDOWN_EN
  localparam logic [COUNT_W-1:0] HOME = TOP;
`else
  localparam logic [COUNT_W-1:0] HOME = '0;
`endif

  logic [1:0]         key_s1;
  logic [1:0]         key_s2;
  logic [1:0]         key_d;
  logic [1:0]         press;
  logic               run_press;
  logic               clr_press;
  logic               step;
  logic               at_wrap;
  logic [COUNT_W-1:0] step_value;
  state_t             state;

  // Two-flop synchronizers plus one history flop for falling-edge detection;
  // all reset to 1 so held-down keys during reset are seen as fresh presses.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      key_d  <= 2'b11;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  // A press is a high-to-low transition of the synchronized key; it lasts one cycle.
  assign press     = key_d & ~key_s2;
  assign run_press = press[0];
  assign clr_press = press[1];

`ifdef SECONDS_COUNTDOWN_EN
  assign at_wrap    = (count == '0);
  assign step_value = at_wrap ? TOP : count - COUNT_W'(1);
`else
  assign at_wrap    = (count == TOP);
  assign step_value = at_wrap ? '0 : count + COUNT_W'(1);
`endif

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en     (state == RUN),
    .clr    (clr_press || (state == IDLE)),
    .tick   (step)
  );

  // Mode FSM with registered outputs; clear beats everything, a step taken in
  // the same cycle as a run press still lands before the pause.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      count   <= HOME;
      running <= 1'b0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clr_press) begin
        state   <= IDLE;
        count   <= HOME;
        running <= 1'b0;
      end else begin
        if (!count_in_range(count)) begin
          count <= HOME;
        end else if (state == IDLE) begin
          count <= HOME;
        end else if (step) begin
          count <= step_value;
          tick  <= 1'b1;
          wrap  <= at_wrap;
        end
        case (state)
          IDLE: begin
            if (run_press) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (run_press) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (run_press) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            count   <= HOME;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seconds_counter.sv
// tb/tb_seconds_counter.sv - self-checking bench for seconds_counter with DIV=4
module tb_seconds_counter;

  localparam int DIV  = 4;
  localparam int MAXC = 59;
`ifdef SECONDS_COUNTDOWN_EN
  localparam int HOME = 59;
`else
  localparam int HOME = 0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [1:0] KEY;
  logic [5:0] count;
  logic       running;
  logic       tick;
  logic       wrap;

  seconds_counter #(
    .DIV (DIV)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .KEY     (KEY),
    .count   (count),
    .running (running),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference model: seconds value, prescale phase and mode as plain integers,
  // plus the last four applied key values (a press is seen three edges late).
  int         m_sec;
  int         m_phase;
  int         m_mode;
  bit         m_tick;
  bit         m_wrap;
  logic [1:0] kh [0:3];

  typedef struct {
    logic [1:0] key;
    int         n;
    int         steps;
    bit         run;
  } vec_t;

  vec_t vecs [0:5];

  function automatic int sec_at(input int steps);
`ifdef SECONDS_COUNTDOWN_EN
    return MAXC - (steps % (MAXC + 1));
`else
    return steps % (MAXC + 1);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) kh[i] = 2'b11;
    m_sec   = HOME;
    m_phase = 0;
    m_mode  = M_IDLE;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] k);
    logic [1:0] pr;
    bit         stepped;
    kh[3] = kh[2];
    kh[2] = kh[1];
    kh[1] = kh[0];
    kh[0] = k;
    pr = kh[3] & ~kh[2];
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (pr[1]) begin
      m_mode  = M_IDLE;
      m_sec   = HOME;
      m_phase = 0;
    end else begin
      stepped = (m_mode == M_RUN) && (m_phase == DIV - 1);
      if (m_mode == M_RUN) m_phase = (m_phase + 1) % DIV;
      if (stepped) begin
`ifdef SECONDS_COUNTDOWN_EN
        m_sec  = (m_sec + MAXC) % (MAXC + 1);
        m_wrap = (m_sec == MAXC);
`else
        m_sec  = (m_sec + 1) % (MAXC + 1);
        m_wrap = (m_sec == 0);
`endif
        m_tick = 1'b1;
      end
      if (pr[0]) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end
  endtask

  task automatic check_outputs();
    check("count",   count,   m_sec);
    check("running", running, (m_mode == M_RUN) ? 1 : 0);
    check("tick",    tick,    m_tick);
    check("wrap",    wrap,    m_wrap);
  endtask

  // Drive a key value for one clock, advance the model, compare on the falling edge.
  task automatic cycle(input logic [1:0] k);
    KEY = k;
    @(posedge Clock);
    model_edge(k);
    @(negedge Clock);
    check_outputs();
  endtask

  initial begin
    int         wraps;
    bit         found;
    logic [1:0] k;
    int         r;

    vecs[0] = '{2'b11, 20, 0, 1'b0};
    vecs[1] = '{2'b10,  3, 0, 1'b1};
    vecs[2] = '{2'b10,  4, 1, 1'b1};
    vecs[3] = '{2'b11,  8, 3, 1'b1};
    vecs[4] = '{2'b00,  3, 0, 1'b0};
    vecs[5] = '{2'b11,  5, 0, 1'b0};

    // Reset for three cycles.
    KEY    = 2'b11;
    Resetn = 1'b0;
    model_reset();
    repeat (3) @(negedge Clock);
    check_outputs();
    Resetn = 1'b1;

    // Table-driven phases: idle, run latency, first ticks, clear+run together.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].n; j++) cycle(vecs[i].key);
      check($sformatf("vec%0d_count", i), count, sec_at(vecs[i].steps));
      check($sformatf("vec%0d_running", i), running, vecs[i].run);
    end

    // Full minute: exactly one wrap, coinciding with the home value.
    cycle(2'b10);
    cycle(2'b10);
    check("run_latency_early", running, 0);
    cycle(2'b10);
    check("run_latency", running, 1);
    wraps = 0;
    for (int i = 0; i < 240; i++) begin
      cycle(2'b11);
      if (wrap) begin
        wraps++;
        check("wrap_value", count, (HOME == 0) ? 0 : MAXC);
      end
    end
    check("wrap_once", wraps, 1);
    check("minute_count", count, HOME);

    // Pause at count 5 with prescaler held at 2, then resume.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_sec == sec_at(4) && m_phase == 3) found = 1'b1;
      else cycle(2'b11);
    end
    check("wait_count4", found, 1);
    repeat (3) cycle(2'b10);
    check("paused", running, 0);
    check("pause_count", count, sec_at(5));
    for (int i = 0; i < 40; i++) begin
      cycle(2'b11);
      check("pause_hold", count, sec_at(5));
    end
    repeat (3) cycle(2'b10);
    check("resumed", running, 1);
    cycle(2'b11);
    check("resume_tick_early", tick, 0);
    cycle(2'b11);
    check("resume_tick", tick, 1);
    check("resume_count", count, sec_at(6));

    // Clear and run pressed together at count 30.
    found = 1'b0;
    for (int i = 0; i < 800 && !found; i++) begin
      if (m_sec == sec_at(30)) found = 1'b1;
      else cycle(2'b11);
    end
    check("wait_count30", found, 1);
    repeat (3) cycle(2'b00);
    check("clear_count", count, HOME);
    check("clear_running", running, 0);
    repeat (4) cycle(2'b11);

    // Asynchronous reset mid-prescale at count 17.
    repeat (3) cycle(2'b10);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_sec == sec_at(17) && m_phase == 1) found = 1'b1;
      else cycle(2'b11);
    end
    check("wait_count17", found, 1);
    #1;
    Resetn = 1'b0;
    KEY    = 2'b10;
    #1;
    check("async_count",   count,   HOME);
    check("async_running", running, 0);
    check("async_tick",    tick,    0);
    check("async_wrap",    wrap,    0);
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;

    // Run key held through reset is accepted on the third edge after release.
    cycle(2'b10);
    cycle(2'b10);
    check("post_reset_early", running, 0);
    cycle(2'b10);
    check("post_reset_run", running, 1);
    repeat (4) cycle(2'b11);
    check("post_reset_first_step", count, sec_at(1));

    // Randomized key activity against the model.
    k = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)   k[0] = ~k[0];
      if (r >= 98) k[1] = ~k[1];
      cycle(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seconds_counter.md
SECONDS_COUNTER -- requirements
Module: seconds_counter

Interface
REQ-001 Parameter DIV, default 50_000_000: Clock cycles per count step (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 KEY  input  2  raw active-low pushbuttons; KEY[0] is run/pause toggle, KEY[1] is clear.
REQ-005 count  output  6  current value, always in 0..59, unsigned binary, for the downstream BCD/seven-segment stage.
REQ-006 running  output  1  high while in RUN.
REQ-007 tick  output  1  one-cycle pulse on each count step.
REQ-008 wrap  output  1  one-cycle pulse on the step that wraps count.

Function
REQ-009 KEY[1:0] SHALL each pass through a 2-flop synchronizer before use.
REQ-010 A press is the high-to-low transition of a synchronized key, detected as a one-cycle event.
REQ-011 Run-key detection latency: the event is registered 3 cycles after the KEY change.
REQ-012 States: IDLE (count 0, stopped), RUN, PAUSE.
REQ-013 IDLE -> RUN on a run press.
REQ-014 RUN -> PAUSE on a run press.
REQ-015 PAUSE -> RUN on a run press.
REQ-016 A clear press from any state -> IDLE, count=0, prescaler=0.
REQ-017 Prescaler counts 0..DIV-1 only in RUN, holds in PAUSE, and is zero in IDLE.
REQ-018 A step SHALL occur in the cycle the prescaler wraps from DIV-1 to 0.
REQ-019 Step behaviour: count increments by 1, tick=1, and 59 -> 0 with wrap=1.
REQ-020 count, tick and wrap SHALL update in the same registered cycle, with zero added latency.
REQ-021 Simultaneous run and clear presses: clear wins and the state becomes IDLE.
REQ-022 Clear in the same cycle as a step: count=0 and tick=wrap=0.
REQ-023 Run press in the same cycle as a step from RUN: the step is taken, then PAUSE; the prescaler holds at 0.
REQ-024 count SHALL never leave 0..59; any out-of-range value is forced to 0 on the next cycle.
REQ-025 The prescaler width SHALL be $clog2(DIV).

Reset
REQ-026 Asserting Resetn low SHALL immediately, without a clock edge, force: state IDLE, count=0, prescaler=0, synchronizers=1 (keys released), running=tick=wrap=0.
REQ-027 Reset mid-RUN SHALL discard the partial prescale, with no tick on release.
REQ-028 The first run press SHALL be accepted no earlier than the 3rd edge after Resetn deasserts.

Configuration
REQ-029 Macro SECONDS_COUNTDOWN_EN controls count direction.
REQ-030 With SECONDS_COUNTDOWN_EN defined: IDLE and clear load 59; steps decrement; 0 -> 59 with wrap=1.
REQ-031 With SECONDS_COUNTDOWN_EN defined: the out-of-range recovery value is 59.
REQ-032 Without SECONDS_COUNTDOWN_EN: behaviour is as REQ-016..REQ-024.

Structure
REQ-033 Shared package seconds_pkg SHALL hold MAX_COUNT=59, COUNT_W=6 and the state enum {IDLE, RUN, PAUSE}.
REQ-034 Sub-module tick_prescaler (params DIV; ports Clock, Resetn, en, clr, tick) SHALL implement REQ-017..REQ-018.
REQ-035 All else in seconds_counter; no latches; every output is registered.

Verification (DIV=4)
REQ-036 Resetn=0 for 3 cycles, release, KEY=2'b11 for 20 cycles -> count=0, running=0, no tick.
REQ-037 Run press -> running=1 three cycles later, then tick every 4 cycles; count 1,2,3 after 3 ticks.
REQ-038 Run from 0 for 240 cycles -> count 59->0 exactly once, one-cycle wrap coinciding with count=0.
REQ-039 At count=5, prescaler=2: run press; hold 40 cycles; run press -> count stays 5 while paused, next tick 2 cycles after resume.
REQ-040 Clear and run pressed in the same cycle at count=30 -> IDLE, count=0, running=0.
REQ-041 Resetn low mid-prescale at count=17 -> outputs 0 asynchronously, before the next edge; with SECONDS_COUNTDOWN_EN, reset count=59 and after 4 cycles of RUN count=58.
